// File: rtl/oled_pkg.sv
// Shared definitions for the OLED serial link: command codes, decoder states,
// FIFO entry layout and the receiver register map.
package oled_pkg;

  localparam logic [7:0] CMD_SET_X     = 8'h15;
  localparam logic [7:0] CMD_SET_Y     = 8'h75;
  localparam logic [7:0] CMD_SET_PIXEL = 8'h5C;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_WINDOW = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_POP    = 2'd3;

  typedef enum logic [2:0] {
    DEC_IDLE  = 3'd0,
    DEC_XARG0 = 3'd1,
    DEC_XARG1 = 3'd2,
    DEC_YARG0 = 3'd3,
    DEC_YARG1 = 3'd4,
    DEC_PIXHI = 3'd5,
    DEC_PIXLO = 3'd6
  } dec_state_e;

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [15:0] pixel;
  } fifo_entry_t;

  // A command byte arriving in one of these states cuts a sequence short.
  function automatic logic cmd_is_proto_err(input dec_state_e s);
    logic r;
    case (s)
      DEC_XARG0, DEC_XARG1, DEC_YARG0, DEC_YARG1, DEC_PIXLO: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/oled_rx_fifo.sv
// Synchronous pixel FIFO; a pop in the same cycle frees room for a push into a full FIFO.
module oled_rx_fifo #(
  parameter int DepthLog2 = 3,
  parameter int Width     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int Depth = 2 ** DepthLog2;

  logic [Width-1:0]     mem_r [Depth];
  logic [DepthLog2-1:0] wr_ptr_r;
  logic [DepthLog2-1:0] rd_ptr_r;
  logic [DepthLog2:0]   count_r;
  logic                 do_pop_s;
  logic                 do_push_s;

  assign full      = count_r[DepthLog2];
  assign empty     = (count_r == '0);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];

  // storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + DepthLog2'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + DepthLog2'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (DepthLog2 + 1)'(1);
        2'b01:   count_r <= count_r - (DepthLog2 + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/oled_sdi_receiver.sv
// OLED 4-wire serial link receiver/monitor with AHB-Lite register access.
// Optional feature macro: OLED_RX_IRQ_EN adds a registered level IRQ output.
module oled_sdi_receiver
  import oled_pkg::*;
#(
  parameter int FifoDepthLog2 = 3,
  parameter int ColMax        = 95,
  parameter int RowMax        = 63
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        nCS,
  input  logic        DnC,
  input  logic        SDIN,
  input  logic        SCLK
`ifdef OLED_RX_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  logic       sclk_q_r;
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       byte_valid_r;
  logic [7:0] byte_data_r;
  logic       byte_dnc_r;
  logic       sclk_rise_s;
  logic [7:0] shift_next_s;
  logic       frame_set_s;

  dec_state_e state_r, next_state_s;
  logic ld_col_start_s, ld_col_end_s, ld_row_start_s, ld_row_end_s;
  logic ld_pix_hi_s, pix_done_s, proto_set_s;

  logic [7:0]  col_start_r, col_end_r, row_start_r, row_end_r;
  logic [7:0]  cur_col_r, cur_row_r, pix_hi_r;
  logic [15:0] count_r;
  logic        frame_err_r, overflow_r, proto_err_r;

  logic        dp_valid_r, dp_write_r;
  logic [1:0]  dp_addr_r;
  logic        rd_s, wr_status_s, wr_count_s;

  fifo_entry_t fifo_wdata_s;
  logic [31:0] fifo_head_s;
  logic        fifo_full_s, fifo_empty_s, fifo_pop_s, overflow_set_s;
  logic        unused_s;

  assign HREADYOUT    = 1'b1;
  assign unused_s     = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:5], HWDATA[1:0]};
  assign sclk_rise_s  = SCLK && !sclk_q_r && !nCS;
  assign shift_next_s = {shift_r[6:0], SDIN};
  assign frame_set_s  = nCS && (bit_cnt_r != 3'd0);

  // serial deserialiser: MSB first, DnC latched with the last bit
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sclk_q_r     <= 1'b0;
      shift_r      <= 8'd0;
      bit_cnt_r    <= 3'd0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'd0;
      byte_dnc_r   <= 1'b0;
    end else begin
      sclk_q_r     <= SCLK;
      byte_valid_r <= 1'b0;
      if (nCS) begin
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        shift_r   <= shift_next_s;
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_valid_r <= 1'b1;
          byte_data_r  <= shift_next_s;
          byte_dnc_r   <= DnC;
        end
      end
    end
  end

  // decoder state register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r <= DEC_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // decoder next state and load strobes; command bytes always restart decoding
  always_comb begin
    next_state_s   = state_r;
    ld_col_start_s = 1'b0;
    ld_col_end_s   = 1'b0;
    ld_row_start_s = 1'b0;
    ld_row_end_s   = 1'b0;
    ld_pix_hi_s    = 1'b0;
    pix_done_s     = 1'b0;
    proto_set_s    = 1'b0;
    if (byte_valid_r && byte_dnc_r) begin
      case (state_r)
        DEC_XARG0: begin ld_col_start_s = 1'b1; next_state_s = DEC_XARG1; end
        DEC_XARG1: begin ld_col_end_s   = 1'b1; next_state_s = DEC_IDLE;  end
        DEC_YARG0: begin ld_row_start_s = 1'b1; next_state_s = DEC_YARG1; end
        DEC_YARG1: begin ld_row_end_s   = 1'b1; next_state_s = DEC_IDLE;  end
        DEC_PIXHI: begin ld_pix_hi_s    = 1'b1; next_state_s = DEC_PIXLO; end
        DEC_PIXLO: begin pix_done_s     = 1'b1; next_state_s = DEC_PIXHI; end
        DEC_IDLE:  begin proto_set_s    = 1'b1; next_state_s = DEC_IDLE;  end
        default:   begin next_state_s   = DEC_IDLE; end
      endcase
    end else if (byte_valid_r) begin
      proto_set_s = cmd_is_proto_err(state_r);
      case (byte_data_r)
        CMD_SET_X:     next_state_s = DEC_XARG0;
        CMD_SET_Y:     next_state_s = DEC_YARG0;
        CMD_SET_PIXEL: next_state_s = DEC_PIXHI;
        default:       next_state_s = DEC_IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // window, cursor and pixel high byte
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      col_start_r <= 8'd0;
      col_end_r   <= 8'(ColMax);
      row_start_r <= 8'd0;
      row_end_r   <= 8'(RowMax);
      cur_col_r   <= 8'd0;
      cur_row_r   <= 8'd0;
      pix_hi_r    <= 8'd0;
    end else begin
      if (ld_col_start_s) col_start_r <= byte_data_r;
      if (ld_row_start_s) row_start_r <= byte_data_r;
      if (ld_pix_hi_s)    pix_hi_r    <= byte_data_r;
      if (ld_col_end_s) begin
        col_end_r <= byte_data_r;
        cur_col_r <= col_start_r;
      end
      if (ld_row_end_s) begin
        row_end_r <= byte_data_r;
        cur_row_r <= row_start_r;
      end
      if (pix_done_s) begin
        if (cur_col_r == col_end_r) begin
          cur_col_r <= col_start_r;
          cur_row_r <= (cur_row_r == row_end_r) ? row_start_r : cur_row_r + 8'd1;
        end else begin
          cur_col_r <= cur_col_r + 8'd1;
        end
      end
    end
  end

  assign rd_s        = dp_valid_r && !dp_write_r;
  assign wr_status_s = dp_valid_r && dp_write_r && (dp_addr_r == REG_STATUS);
  assign wr_count_s  = dp_valid_r && dp_write_r && (dp_addr_r == REG_COUNT);
  assign fifo_pop_s  = rd_s && (dp_addr_r == REG_POP) && !fifo_empty_s;
  assign overflow_set_s = pix_done_s && fifo_full_s && !fifo_pop_s;
  assign fifo_wdata_s   = '{row: cur_row_r, col: cur_col_r, pixel: {pix_hi_r, byte_data_r}};

  // pixel count (saturating) and sticky flags; a set beats a same-cycle clear
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      count_r     <= 16'd0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      if (wr_count_s) begin
        count_r <= 16'd0;
      end else if (pix_done_s && (count_r != 16'hFFFF)) begin
        count_r <= count_r + 16'd1;
      end
      frame_err_r <= frame_set_s    | (frame_err_r & ~(wr_status_s & HWDATA[2]));
      overflow_r  <= overflow_set_s | (overflow_r  & ~(wr_status_s & HWDATA[3]));
      proto_err_r <= proto_set_s    | (proto_err_r & ~(wr_status_s & HWDATA[4]));
    end
  end

  // AHB address phase capture
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_addr_r  <= 2'd0;
    end else begin
      dp_valid_r <= HREADY && HSEL && (HTRANS != 2'b00);
      dp_write_r <= HWRITE;
      dp_addr_r  <= HADDR[3:2];
    end
  end

  // read mux for the current data phase
  always_comb begin
    HRDATA = 32'd0;
    if (rd_s) begin
      case (dp_addr_r)
        REG_STATUS: HRDATA = {27'd0, proto_err_r, overflow_r, frame_err_r, fifo_full_s, !fifo_empty_s};
        REG_WINDOW: HRDATA = {row_end_r, row_start_r, col_end_r, col_start_r};
        REG_COUNT:  HRDATA = {16'd0, count_r};
        REG_POP:    HRDATA = fifo_empty_s ? 32'd0 : fifo_head_s;
        default:    HRDATA = 32'd0;
      endcase
    end else begin
      HRDATA = 32'd0;
    end
  end

  oled_rx_fifo #(
    .DepthLog2 (FifoDepthLog2),
    .Width     (32)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (pix_done_s),
    .pop   (fifo_pop_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

`ifdef OLED_RX_IRQ_EN
  logic irq_r;
  assign IRQ = irq_r;

  // level interrupt: pending pixels or any sticky error
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= !fifo_empty_s | frame_err_r | overflow_r | proto_err_r;
    end
  end
`endif

endmodule
